// File: rtl/lcd_digit_writer.sv
// Writes two character pairs to an HD44780 LCD (8-bit mode) as the field "TT:OO".
// Owns the power-up wait, the init command sequence and all enable-strobe timing.
module lcd_digit_writer #(
  parameter int unsigned P_PWR_WAIT  = 750000,
  parameter int unsigned P_EN_CYCLES = 12,
  parameter int unsigned P_CMD_WAIT  = 2500,
  parameter int unsigned P_CLR_WAIT  = 100000,
  parameter logic [6:0]  P_ADDR      = 7'h00
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [15:0] i_pair_hi,
  input  logic [15:0] i_pair_lo,
  input  logic        i_update,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic        o_lcd_e,
  output logic [7:0]  o_lcd_data
);

  localparam logic [1:0] S_PWR   = 2'd0;
  localparam logic [1:0] S_INIT  = 2'd1;
  localparam logic [1:0] S_IDLE  = 2'd2;
  localparam logic [1:0] S_FRAME = 2'd3;

  localparam logic [1:0] PH_SETUP = 2'd0;
  localparam logic [1:0] PH_EN    = 2'd1;
  localparam logic [1:0] PH_WAIT  = 2'd2;

  localparam logic [19:0] PWR_LAST = 20'(P_PWR_WAIT - 1);
  localparam logic [19:0] EN_LAST  = 20'(P_EN_CYCLES - 1);
  localparam logic [19:0] CMD_LAST = 20'(P_CMD_WAIT - 1);
  localparam logic [19:0] CLR_LAST = 20'(P_CLR_WAIT - 1);

  logic [1:0]  state_q, state_d;
  logic [1:0]  phase_q, phase_d;
  logic [19:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [31:0] frame_q, frame_d;
  logic [31:0] pend_q, pend_d;
  logic        pending_q, pending_d;
  logic        e_q, e_d;
  logic        rs_q, rs_d;
  logic [7:0]  data_q, data_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;

  logic [2:0]  last_idx;
  logic        clr_byte;

  function automatic logic [7:0] init_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    init_byte = 8'h38;
      3'd1:    init_byte = 8'h0C;
      3'd2:    init_byte = 8'h06;
      default: init_byte = 8'h01;
    endcase
  endfunction

  function automatic logic [7:0] frame_byte(input logic [2:0] idx, input logic [31:0] f);
    case (idx)
      3'd0:    frame_byte = {1'b1, P_ADDR};
      3'd1:    frame_byte = f[31:24];
      3'd2:    frame_byte = f[23:16];
      3'd3:    frame_byte = 8'h3A;
      3'd4:    frame_byte = f[15:8];
      default: frame_byte = f[7:0];
    endcase
  endfunction

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    frame_d   = frame_q;
    pend_d    = pend_q;
    pending_d = pending_q;
    last_idx  = (state_q == S_INIT) ? 3'd3 : 3'd5;
    clr_byte  = (state_q == S_INIT) && (idx_q == 3'd3);

    // Requests arriving while busy are parked; the end-of-sequence logic may consume them.
    if (i_update && (state_q != S_IDLE)) begin
      pend_d    = {i_pair_hi, i_pair_lo};
      pending_d = 1'b1;
    end

    case (state_q)
      S_PWR: begin
        if (cnt_q == PWR_LAST) begin
          state_d = S_INIT;
          phase_d = PH_SETUP;
          idx_d   = 3'd0;
          cnt_d   = 20'd0;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      S_IDLE: begin
        if (i_update) begin
          frame_d = {i_pair_hi, i_pair_lo};
          state_d = S_FRAME;
          phase_d = PH_SETUP;
          idx_d   = 3'd0;
          cnt_d   = 20'd0;
        end
      end
      default: begin
        case (phase_q)
          PH_SETUP: begin
            phase_d = PH_EN;
            cnt_d   = EN_LAST;
          end
          PH_EN: begin
            if (cnt_q == 20'd0) begin
              phase_d = PH_WAIT;
              cnt_d   = clr_byte ? CLR_LAST : CMD_LAST;
            end else begin
              cnt_d = cnt_q - 20'd1;
            end
          end
          default: begin
            if (cnt_q != 20'd0) begin
              cnt_d = cnt_q - 20'd1;
            end else if (idx_q != last_idx) begin
              idx_d   = idx_q + 3'd1;
              phase_d = PH_SETUP;
            end else begin
              // Fresh request beats the parked one; either starts a frame with no idle gap.
              phase_d = PH_SETUP;
              idx_d   = 3'd0;
              cnt_d   = 20'd0;
              if (i_update) begin
                frame_d   = {i_pair_hi, i_pair_lo};
                state_d   = S_FRAME;
                pending_d = 1'b0;
              end else if (pending_q) begin
                frame_d   = pend_q;
                state_d   = S_FRAME;
                pending_d = 1'b0;
              end else begin
                state_d = S_IDLE;
              end
            end
          end
        endcase
      end
    endcase

    // Outputs are decoded from the next state so that every pin comes straight from a flop.
    data_d = data_q;
    rs_d   = rs_q;
    if (state_d == S_INIT) begin
      rs_d   = 1'b0;
      data_d = init_byte(idx_d);
    end else if (state_d == S_FRAME) begin
      rs_d   = (idx_d != 3'd0);
      data_d = frame_byte(idx_d, frame_d);
    end
    e_d    = ((state_d == S_INIT) || (state_d == S_FRAME)) && (phase_d == PH_EN);
    done_d = (state_d == S_FRAME) && (phase_d == PH_WAIT) && (cnt_d == 20'd0) && (idx_d == 3'd5);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= S_PWR;
      phase_q   <= PH_SETUP;
      cnt_q     <= 20'd0;
      idx_q     <= 3'd0;
      pending_q <= 1'b0;
      e_q       <= 1'b0;
      rs_q      <= 1'b0;
      data_q    <= 8'h00;
      done_q    <= 1'b0;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      e_q       <= e_d;
      rs_q      <= rs_d;
      data_q    <= data_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  always_ff @(posedge i_clk) begin
    frame_q <= frame_d;
    pend_q  <= pend_d;
  end

  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_lcd_rs   = rs_q;
  assign o_lcd_rw   = 1'b0;
  assign o_lcd_e    = e_q;
  assign o_lcd_data = data_q;

endmodule

// File: tb/tb_lcd_digit_writer.sv
// Bench for lcd_digit_writer: randomized and directed stimulus, a timing-level
// reference model feeding scoreboards, and a monitor that compares LCD bus activity.
module tb_lcd_digit_writer;

  localparam int PWR       = 20;
  localparam int EN        = 2;
  localparam int CMD       = 3;
  localparam int CLR       = 10;
  localparam int SLOT      = 1 + EN + CMD;
  localparam int FRAME_LEN = 6 * SLOT;
  localparam int INIT_LEN  = PWR + 3 * SLOT + 1 + EN + CLR;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] hi = 16'h0;
  logic [15:0] lo = 16'h0;
  logic        upd = 1'b0;
  logic        o_busy, o_done, o_lcd_rs, o_lcd_rw, o_lcd_e;
  logic [7:0]  o_lcd_data;

  lcd_digit_writer #(
    .P_PWR_WAIT (PWR),
    .P_EN_CYCLES(EN),
    .P_CMD_WAIT (CMD),
    .P_CLR_WAIT (CLR),
    .P_ADDR     (7'h40)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_pair_hi (hi),
    .i_pair_lo (lo),
    .i_update  (upd),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_lcd_rs  (o_lcd_rs),
    .o_lcd_rw  (o_lcd_rw),
    .o_lcd_e   (o_lcd_e),
    .o_lcd_data(o_lcd_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed { int t; logic rs; logic [7:0] d; } byte_t;
  typedef struct packed { int t; logic b; } busy_t;

  byte_t exp_bytes[$];
  int    exp_done[$];
  busy_t exp_busy[$];

  int tests = 0;
  int fails = 0;

  // Reference model: cycle of the last activity cycle and the single parked request.
  int          cur_end = 0;
  logic        pend_v = 1'b0;
  logic [15:0] pend_hi = 16'h0;
  logic [15:0] pend_lo = 16'h0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_init(input int r);
    logic [7:0] cmds [4];
    cmds = '{8'h38, 8'h0C, 8'h06, 8'h01};
    for (int k = 0; k < 4; k++)
      exp_bytes.push_back('{r + PWR + 1 + k * SLOT, 1'b0, cmds[k]});
    cur_end = r + INIT_LEN - 1;
  endtask

  task automatic start_frame(input int s, input logic [15:0] h, input logic [15:0] l);
    logic [7:0] b [6];
    b = '{8'hC0, h[15:8], h[7:0], 8'h3A, l[15:8], l[7:0]};
    for (int k = 0; k < 6; k++)
      exp_bytes.push_back('{s + k * SLOT + 1, (k != 0), b[k]});
    exp_done.push_back(s + FRAME_LEN - 1);
    cur_end = s + FRAME_LEN - 1;
  endtask

  // One cycle of stimulus plus the model's view of that cycle.
  task automatic step(input bit rst, input bit u, input logic [15:0] h, input logic [15:0] l);
    int n;
    @(negedge clk);
    n     = cyc;
    rst_n = !rst;
    upd   = u;
    hi    = u ? h : 16'($urandom);
    lo    = u ? l : 16'($urandom);
    if (rst) begin
      exp_bytes.delete();
      exp_done.delete();
      pend_v = 1'b0;
      expect_init(n + 1);
    end else if (u) begin
      if (n >= cur_end) begin
        pend_v = 1'b0;
        start_frame(n + 1, h, l);
      end else begin
        pend_v  = 1'b1;
        pend_hi = h;
        pend_lo = l;
      end
    end else if (pend_v && n == cur_end) begin
      pend_v = 1'b0;
      start_frame(n + 1, pend_hi, pend_lo);
    end
    exp_busy.push_back('{n + 1, ((n + 1) <= cur_end)});
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  initial begin
    logic  e_prev;
    int    e_w;
    byte_t bt;
    busy_t bb;
    int    dt;
    e_prev = 1'b0;
    e_w    = 0;
    forever begin
      @(posedge clk);
      #1;
      while (exp_busy.size() > 0 && exp_busy[0].t < cyc) void'(exp_busy.pop_front());
      if (exp_busy.size() > 0 && exp_busy[0].t == cyc) begin
        bb = exp_busy.pop_front();
        check("busy", int'(o_busy), int'(bb.b));
      end
      if (!rst_n) begin
        check("rst_e", int'(o_lcd_e), 0);
        check("rst_data", int'(o_lcd_data), 0);
        check("rst_rs", int'(o_lcd_rs), 0);
        check("rst_done", int'(o_done), 0);
        check("rst_busy", int'(o_busy), 1);
        e_prev = 1'b0;
        e_w    = 0;
        continue;
      end
      if (o_lcd_e && !e_prev) begin
        if (exp_bytes.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL e_rise: unexpected strobe data %0h rs %0d (cycle %0d)", o_lcd_data, o_lcd_rs, cyc);
        end else begin
          bt = exp_bytes.pop_front();
          check("e_time", cyc, bt.t);
          check("byte", int'({o_lcd_rs, o_lcd_data}), int'({bt.rs, bt.d}));
          check("rw", int'(o_lcd_rw), 0);
        end
        e_w = 1;
      end else if (o_lcd_e) begin
        e_w++;
      end else if (e_prev) begin
        check("e_width", e_w, EN);
      end
      e_prev = o_lcd_e;
      while (exp_bytes.size() > 0 && exp_bytes[0].t < cyc) begin
        bt = exp_bytes.pop_front();
        check("e_missing", 0, int'(bt.d));
      end
      if (o_done) begin
        if (exp_done.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL done: unexpected pulse got 1, expected 0 (cycle %0d)", cyc);
        end else begin
          dt = exp_done.pop_front();
          check("done_time", cyc, dt);
          check("done_busy", int'(o_busy), 1);
        end
      end
      while (exp_done.size() > 0 && exp_done[0] < cyc) begin
        dt = exp_done.pop_front();
        check("done_missing", cyc, dt);
      end
    end
  end

  initial begin
    // Power-up with no requests.
    repeat (3) step(1'b1, 1'b0, 16'h0, 16'h0);
    idle(60);
    // Single frame from idle.
    step(1'b0, 1'b1, 16'h3132, 16'h3435);
    idle(40);
    // Two requests during a frame: only the latest one is written afterwards.
    step(1'b0, 1'b1, 16'(32'h3100 + $urandom_range(0, 9) * 256 + 32'h30), 16'h3536);
    idle(10);
    step(1'b0, 1'b1, 16'h3030, 16'h3030);
    idle(8);
    step(1'b0, 1'b1, 16'h3939, 16'h3838);
    idle(80);
    // Request during the power-up wait.
    step(1'b1, 1'b0, 16'h0, 16'h0);
    idle(5);
    step(1'b0, 1'b1, 16'h3237, 16'h3539);
    idle(100);
    // Reset while E is high inside a frame.
    step(1'b0, 1'b1, 16'h3131, 16'h3232);
    idle(1);
    step(1'b1, 1'b0, 16'h0, 16'h0);
    idle(70);
    // Request on the exact done cycle.
    step(1'b0, 1'b1, 16'h3334, 16'h3536);
    idle(35);
    step(1'b0, 1'b1, 16'h3738, 16'h3930);
    idle(45);
    // Randomized traffic with occasional resets.
    for (int i = 0; i < 700; i++) begin
      if ($urandom_range(0, 399) == 0)
        step(1'b1, 1'b0, 16'h0, 16'h0);
      else if ($urandom_range(0, 19) == 0)
        step(1'b0, 1'b1, 16'($urandom), 16'($urandom));
      else
        step(1'b0, 1'b0, 16'h0, 16'h0);
    end
    idle(150);
    check("bytes_left", exp_bytes.size(), 0);
    check("done_left", exp_done.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
